seg_counter_n: RTL and testbench
================================

Name: seg_counter_n

Overview:
- Parametrised multi-digit up/down counter driving DIGITS seven-segment displays.
- Counts in hex or BCD at a programmable rate derived from CLOCK_50, with pause and synchronous clear.
- Successor to the fixed 8-digit pausable display counter. Sits between board switches and the HEX display pins of the top level.

Parameters:
- DIGITS, 8, number of 4-bit digits/displays (1..8).
- PRESCALE, 50000000, CLOCK_50 cycles per count step (>=1; 1 = step every cycle).
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 never blanked).

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- sw_pause  in  1  level; 1 holds prescaler and count.
- sw_down  in  1  level; 0 = count up, 1 = count down.
- sw_bcd  in  1  level; 0 = hex digits 0-f, 1 = BCD digits 0-9.
- clear  in  1  synchronous; count and prescaler to 0.
- count  out  4*DIGITS  current count, digit k at [4k+3:4k].
- HEX  out  7*DIGITS  active-low segments, display k at [7k+6:7k], bit order {g,f,e,d,c,b,a}.
- wrap  out  1  one-cycle pulse on the step that wraps the full count.

Behaviour:
- Reset (async assert): count=0, prescaler=0, wrap=0.
  - HEX digit 0 = 7'b1000000.
  - Other digits = 7'b1000000 when BLANK_LZ=0, else 7'b1111111.
  - Deassert takes effect on the next rising edge.
- Prescaler runs 0..PRESCALE-1 and advances each cycle unless sw_pause=1 (holds value).
  - At PRESCALE-1 (not paused) it returns to 0 and asserts internal step for that cycle.
- On step, count changes by ±1 on the same edge. Digit radix R = 16 (hex) or 10 (BCD).
  - Up: digit 0 increments. A digit at R-1 rolls to 0 and carries into the next digit.
  - Down: a digit at 0 rolls to R-1 and borrows from the next digit.
- Full wrap:
  - Up from all digits R-1 goes to all 0.
  - Down from all 0 goes to all R-1.
  - wrap=1 for exactly the cycle following that edge (registered); otherwise 0.
- sw_bcd change: detected by a registered copy of sw_bcd. The cycle after any change, count is forced to 0 (prescaler untouched, no wrap). This prevents illegal BCD digits.
- Priority on one edge: reset > clear > bcd-change clear > step.
  - clear also zeroes the prescaler.
  - clear with step: step is discarded.
- Direction change takes effect on the next step; no extra step is generated.
- Pause asserted on the step cycle: step suppressed, prescaler holds at PRESCALE-1. The step fires on the first unpaused cycle.
- Segment encoding (hex values 0-f), registered, HEX valid 1 cycle after count:
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000
  - 4: 0011001, 5: 0010010, 6: 0000010, 7: 1111000
  - 8: 0000000, 9: 0011000, a: 0001000, b: 0000011
  - c: 0100111, d: 0100001, e: 0000110, f: 0001110
- Blanking (BLANK_LZ=1): digit k>0 outputs 7'b1111111 when it and all higher digits are 0.
- count output is the state register: no latency after the step edge.

Test Plan:
- DIGITS=2, PRESCALE=2, hex, up, from reset: count steps every 2 cycles 00,01..0f,10. HEX0 shows 1111001 one cycle after count=01.
- Count up from ff, one step: count=00, wrap=1 for one cycle, HEX = 1000000,1000000.
- sw_bcd=1, count up from 09: next value is 10. From 99 the next value is 00 with wrap. sw_down=1 from 00 gives 99 with wrap.
- sw_pause=1 held 10 cycles at count=05: count and prescaler frozen. Release: next step occurs after the remaining prescale cycles, count=06.
- sw_bcd toggled 0->1 while count=3c: count=00 on the following cycle, no wrap. clear asserted on a step cycle: count=00, prescaler=0, no increment.
- reset asserted mid-prescale (asynchronous, between edges): count, wrap and HEX go to reset values immediately. BLANK_LZ=1, DIGITS=4, count=0007: HEX3..HEX1 = 1111111, HEX0 = 1111000.

Source files
------------

// File: rtl/seg_counter_n.sv
// DIGITS-wide hex/BCD up/down counter stepped by a CLOCK_50 prescaler, with
// pause, synchronous clear, a full-wrap pulse and registered 7-segment outputs.
module seg_counter_n #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 50000000,
    parameter int BLANK_LZ = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  sw_pause,
    input  logic                  sw_down,
    input  logic                  sw_bcd,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  wrap
);
    localparam int CW = 4 * DIGITS;
    localparam int HW = 7 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] cnt_stepped;
    logic [HW-1:0] hex_q;
    logic          wrap_q, wrap_d;
    logic          bcd_q;
    logic          step;
    logic          bcd_chg;
    logic          full_wrap;
    logic [3:0]    dig;
    logic [3:0]    dmax;
    logic          carry;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0011000;
            4'ha:    s = 7'b0001000;
            4'hb:    s = 7'b0000011;
            4'hc:    s = 7'b0100111;
            4'hd:    s = 7'b0100001;
            4'he:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Leading-zero run is tracked from the top digit down; digit 0 always shows.
    function automatic logic [HW-1:0] display(input logic [CW-1:0] c);
        logic [HW-1:0] h;
        logic          lead;
        h    = '0;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead = lead && (c[4*k +: 4] == 4'd0);
            if ((BLANK_LZ != 0) && (k != 0) && lead)
                h[7*k +: 7] = 7'b1111111;
            else
                h[7*k +: 7] = seg7(c[4*k +: 4]);
        end
        return h;
    endfunction

    // Ripple carry/borrow through the digits; a carry out of the top digit is a full wrap.
    always_comb begin
        cnt_stepped = count_q;
        dig         = '0;
        dmax        = sw_bcd ? 4'd9 : 4'd15;
        carry       = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            dig = count_q[4*k +: 4];
            if (carry) begin
                if (sw_down) begin
                    cnt_stepped[4*k +: 4] = (dig == 4'd0) ? dmax : dig - 4'd1;
                    carry                 = (dig == 4'd0);
                end else begin
                    cnt_stepped[4*k +: 4] = (dig == dmax) ? 4'd0 : dig + 4'd1;
                    carry                 = (dig == dmax);
                end
            end
        end
        full_wrap = carry;
    end

    always_comb begin
        step    = !sw_pause && (presc_q == PRE_LAST);
        bcd_chg = (sw_bcd != bcd_q);
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (!sw_pause)
            presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
        if (clear) begin
            count_d = '0;
            presc_d = '0;
        end else if (bcd_chg) begin
            count_d = '0;
        end else if (step) begin
            count_d = cnt_stepped;
            wrap_d  = full_wrap;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            bcd_q   <= 1'b0;
            hex_q   <= display('0);
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            bcd_q   <= sw_bcd;
            hex_q   <= display(count_q);
        end
    end

    assign count = count_q;
    assign HEX   = hex_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_seg_counter_n.sv
// Self-checking bench for seg_counter_n: two instances (2-digit hex/no blanking,
// 4-digit with leading-zero blanking) checked against an integer-valued model.
module tb_seg_counter_n;
    localparam int DA = 2;
    localparam int PA = 2;
    localparam int DB = 4;
    localparam int PB = 3;
    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] SF  = 7'b0001110;
    localparam logic [6:0] SBL = 7'b1111111;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    logic sw_pause = 1'b0;
    logic sw_down  = 1'b0;
    logic sw_bcd   = 1'b0;
    logic clear    = 1'b0;

    logic [4*DA-1:0] count_a;
    logic [7*DA-1:0] hex_a;
    logic            wrap_a;
    logic [4*DB-1:0] count_b;
    logic [7*DB-1:0] hex_b;
    logic            wrap_b;

    int errors = 0;
    int checks = 0;

    logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                             7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 CLOCK_50 = ~CLOCK_50;

    seg_counter_n #(.DIGITS(DA), .PRESCALE(PA), .BLANK_LZ(0)) dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .sw_pause(sw_pause), .sw_down(sw_down),
        .sw_bcd(sw_bcd), .clear(clear), .count(count_a), .HEX(hex_a), .wrap(wrap_a)
    );

    seg_counter_n #(.DIGITS(DB), .PRESCALE(PB), .BLANK_LZ(1)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .sw_pause(sw_pause), .sw_down(sw_down),
        .sw_bcd(sw_bcd), .clear(clear), .count(count_b), .HEX(hex_b), .wrap(wrap_b)
    );

    // Reference model: the count is held as an integer in radix R and converted to digits.
    logic [15:0] m_cnt  [2];
    logic [27:0] m_hex  [2];
    logic        m_wrap [2];
    int          m_pre  [2];
    logic        m_bcdq;

    function automatic int nd_of(input int i);
        return (i == 0) ? DA : DB;
    endfunction

    function automatic int to_int(input logic [15:0] c, input int nd, input int r);
        int v;
        v = 0;
        for (int k = nd - 1; k >= 0; k--) v = v * r + int'(c[4*k +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] to_dig(input int val, input int nd, input int r);
        logic [15:0] c;
        int          v;
        c = '0;
        v = val;
        for (int k = 0; k < nd; k++) begin
            c[4*k +: 4] = 4'(v % r);
            v = v / r;
        end
        return c;
    endfunction

    function automatic logic [27:0] exp_hex(input logic [15:0] c, input int nd, input bit blz);
        logic [27:0] h;
        bit          z;
        h = '0;
        z = 1'b1;
        for (int k = nd - 1; k >= 0; k--) begin
            z = z && (c[4*k +: 4] == 4'd0);
            h[7*k +: 7] = (blz && k > 0 && z) ? 7'b1111111 : SEG[c[4*k +: 4]];
        end
        return h;
    endfunction

    always @(posedge CLOCK_50 or posedge reset) begin
        int   r;
        int   m;
        int   v;
        int   pl;
        logic stp;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i]  = '0;
                m_pre[i]  = 0;
                m_wrap[i] = 1'b0;
                m_hex[i]  = exp_hex('0, nd_of(i), i == 1);
            end
            m_bcdq = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_hex[i]  = exp_hex(m_cnt[i], nd_of(i), i == 1);
                r         = sw_bcd ? 10 : 16;
                m         = r ** nd_of(i);
                pl        = (i == 0) ? PA : PB;
                stp       = !sw_pause && (m_pre[i] == pl - 1);
                m_wrap[i] = 1'b0;
                if (!sw_pause) m_pre[i] = (m_pre[i] + 1) % pl;
                if (clear) begin
                    m_cnt[i] = '0;
                    m_pre[i] = 0;
                end else if (sw_bcd != m_bcdq) begin
                    m_cnt[i] = '0;
                end else if (stp) begin
                    v = to_int(m_cnt[i], nd_of(i), r);
                    if (sw_down) begin
                        m_wrap[i] = (v == 0);
                        v = (v + m - 1) % m;
                    end else begin
                        m_wrap[i] = (v == m - 1);
                        v = (v + 1) % m;
                    end
                    m_cnt[i] = to_dig(v, nd_of(i), r);
                end
            end
            m_bcdq = sw_bcd;
        end
    end

    task automatic test_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL reset_count_a: got %h want 00", count_a); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset_wrap_a: got %b want 0", wrap_a); end
        checks++; if (hex_a !== {S0, S0}) begin errors++; $display("FAIL reset_hex_a: got %b want %b", hex_a, {S0, S0}); end
        checks++; if (count_b !== 16'h0000) begin errors++; $display("FAIL reset_count_b: got %h want 0000", count_b); end
        checks++; if (hex_b !== {SBL, SBL, SBL, S0}) begin errors++; $display("FAIL reset_hex_b: got %b want %b", hex_b, {SBL, SBL, SBL, S0}); end
        reset = 1'b0;
    endtask

    task automatic test_hex_up();
        bit pend1;
        bit done1;
        pend1 = 1'b0;
        done1 = 1'b0;
        for (int n = 0; n < 32; n++) begin
            @(negedge CLOCK_50);
            checks++; if (count_a !== m_cnt[0][7:0]) begin errors++; $display("FAIL hexup_count: got %h want %h", count_a, m_cnt[0][7:0]); end
            checks++; if (hex_a !== m_hex[0][13:0]) begin errors++; $display("FAIL hexup_hex: got %b want %b", hex_a, m_hex[0][13:0]); end
            if (pend1) begin
                checks++; if (hex_a[6:0] !== S1) begin errors++; $display("FAIL hexup_hex0_after_01: got %b want %b", hex_a[6:0], S1); end
                pend1 = 1'b0;
            end
            if (!done1 && count_a === 8'h01) begin
                checks++; if (hex_a[6:0] !== S0) begin errors++; $display("FAIL hexup_hex_latency: got %b want %b", hex_a[6:0], S0); end
                pend1 = 1'b1;
                done1 = 1'b1;
            end
        end
        checks++; if (count_a !== 8'h10) begin errors++; $display("FAIL hexup_final: got %h want 10", count_a); end
    endtask

    task automatic test_wrap_hex();
        clear   = 1'b1;
        sw_down = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL wrap_clear: got %h want 00", count_a); end
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++; if (count_a !== 8'hff) begin errors++; $display("FAIL wrap_down_count: got %h want ff", count_a); end
        checks++; if (wrap_a !== 1'b1) begin errors++; $display("FAIL wrap_down_pulse: got %b want 1", wrap_a); end
        sw_down = 1'b0;
        @(negedge CLOCK_50);
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL wrap_pulse_width: got %b want 0", wrap_a); end
        checks++; if (hex_a !== {SF, SF}) begin errors++; $display("FAIL wrap_hex_ff: got %b want %b", hex_a, {SF, SF}); end
        @(negedge CLOCK_50);
        checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL wrap_up_count: got %h want 00", count_a); end
        checks++; if (wrap_a !== 1'b1) begin errors++; $display("FAIL wrap_up_pulse: got %b want 1", wrap_a); end
        @(negedge CLOCK_50);
        checks++; if (hex_a !== {S0, S0}) begin errors++; $display("FAIL wrap_up_hex: got %b want %b", hex_a, {S0, S0}); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL wrap_up_width: got %b want 0", wrap_a); end
    endtask

    task automatic test_bcd();
        clear  = 1'b1;
        sw_bcd = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        for (int n = 0; n < 40 && count_a !== 8'h09; n++) @(negedge CLOCK_50);
        checks++; if (count_a !== 8'h09) begin errors++; $display("FAIL bcd_reach09: got %h want 09", count_a); end
        for (int n = 0; n < 4 && count_a === 8'h09; n++) @(negedge CLOCK_50);
        checks++; if (count_a !== 8'h10) begin errors++; $display("FAIL bcd_09_to_10: got %h want 10", count_a); end
        clear   = 1'b1;
        sw_down = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        for (int n = 0; n < 6 && count_a === 8'h00; n++) @(negedge CLOCK_50);
        checks++; if (count_a !== 8'h99) begin errors++; $display("FAIL bcd_down_wrap: got %h want 99", count_a); end
        checks++; if (wrap_a !== 1'b1) begin errors++; $display("FAIL bcd_down_wrap_pulse: got %b want 1", wrap_a); end
        checks++; if (count_b !== m_cnt[1]) begin errors++; $display("FAIL bcd_down_b: got %h want %h", count_b, m_cnt[1]); end
        sw_down = 1'b0;
        for (int n = 0; n < 6 && count_a === 8'h99; n++) @(negedge CLOCK_50);
        checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL bcd_up_wrap: got %h want 00", count_a); end
        checks++; if (wrap_a !== 1'b1) begin errors++; $display("FAIL bcd_up_wrap_pulse: got %b want 1", wrap_a); end
    endtask

    task automatic test_pause();
        clear  = 1'b1;
        sw_bcd = 1'b0;
        @(negedge CLOCK_50);
        clear = 1'b0;
        for (int n = 0; n < 20 && count_a !== 8'h05; n++) @(negedge CLOCK_50);
        checks++; if (count_a !== 8'h05) begin errors++; $display("FAIL pause_reach05: got %h want 05", count_a); end
        @(negedge CLOCK_50);
        sw_pause = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge CLOCK_50);
            checks++; if (count_a !== 8'h05) begin errors++; $display("FAIL pause_hold: got %h want 05", count_a); end
            checks++; if (count_b !== m_cnt[1]) begin errors++; $display("FAIL pause_hold_b: got %h want %h", count_b, m_cnt[1]); end
        end
        sw_pause = 1'b0;
        @(negedge CLOCK_50);
        checks++; if (count_a !== 8'h06) begin errors++; $display("FAIL pause_release: got %h want 06", count_a); end
    endtask

    task automatic test_bcd_change();
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        for (int n = 0; n < 140 && count_a !== 8'h3c; n++) @(negedge CLOCK_50);
        checks++; if (count_a !== 8'h3c) begin errors++; $display("FAIL bcdchg_reach3c: got %h want 3c", count_a); end
        sw_bcd = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL bcdchg_count: got %h want 00", count_a); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL bcdchg_wrap: got %b want 0", wrap_a); end
        checks++; if (count_b !== m_cnt[1]) begin errors++; $display("FAIL bcdchg_b: got %h want %h", count_b, m_cnt[1]); end
    endtask

    task automatic test_clear_step();
        for (int n = 0; n < 6 && count_a === 8'h00; n++) @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL clrstep_count: got %h want 00", count_a); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL clrstep_wrap: got %b want 0", wrap_a); end
        for (int n = 0; n < 2; n++) begin
            @(negedge CLOCK_50);
            checks++; if (count_b !== m_cnt[1]) begin errors++; $display("FAIL clrstep_b: got %h want %h", count_b, m_cnt[1]); end
        end
        checks++; if (count_a !== 8'h01) begin errors++; $display("FAIL clrstep_restart: got %h want 01", count_a); end
    endtask

    task automatic test_blank();
        @(negedge CLOCK_50);
        reset    = 1'b1;
        sw_bcd   = 1'b0;
        sw_down  = 1'b0;
        sw_pause = 1'b0;
        @(negedge CLOCK_50);
        reset = 1'b0;
        for (int n = 0; n < 40 && count_b !== 16'h0007; n++) @(negedge CLOCK_50);
        checks++; if (count_b !== 16'h0007) begin errors++; $display("FAIL blank_reach7: got %h want 0007", count_b); end
        @(negedge CLOCK_50);
        checks++; if (hex_b !== {SBL, SBL, SBL, S7}) begin errors++; $display("FAIL blank_hex_0007: got %b want %b", hex_b, {SBL, SBL, SBL, S7}); end
        checks++; if (hex_a !== m_hex[0][13:0]) begin errors++; $display("FAIL blank_hex_a: got %b want %b", hex_a, m_hex[0][13:0]); end
    endtask

    task automatic test_async_reset();
        @(negedge CLOCK_50);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (count_a !== 8'h00) begin errors++; $display("FAIL areset_count_a: got %h want 00", count_a); end
        checks++; if (count_b !== 16'h0000) begin errors++; $display("FAIL areset_count_b: got %h want 0000", count_b); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL areset_wrap: got %b want 0", wrap_a); end
        checks++; if (hex_a !== {S0, S0}) begin errors++; $display("FAIL areset_hex_a: got %b want %b", hex_a, {S0, S0}); end
        checks++; if (hex_b !== {SBL, SBL, SBL, S0}) begin errors++; $display("FAIL areset_hex_b: got %b want %b", hex_b, {SBL, SBL, SBL, S0}); end
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge CLOCK_50);
            checks++; if (count_a !== m_cnt[0][7:0]) begin errors++; $display("FAIL rand_count_a: got %h want %h", count_a, m_cnt[0][7:0]); end
            checks++; if (hex_a !== m_hex[0][13:0]) begin errors++; $display("FAIL rand_hex_a: got %b want %b", hex_a, m_hex[0][13:0]); end
            checks++; if (wrap_a !== m_wrap[0]) begin errors++; $display("FAIL rand_wrap_a: got %b want %b", wrap_a, m_wrap[0]); end
            checks++; if (count_b !== m_cnt[1]) begin errors++; $display("FAIL rand_count_b: got %h want %h", count_b, m_cnt[1]); end
            checks++; if (hex_b !== m_hex[1]) begin errors++; $display("FAIL rand_hex_b: got %b want %b", hex_b, m_hex[1]); end
            checks++; if (wrap_b !== m_wrap[1]) begin errors++; $display("FAIL rand_wrap_b: got %b want %b", wrap_b, m_wrap[1]); end
            sw_pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) sw_down = ~sw_down;
            if ($urandom_range(0, 39) == 0) sw_bcd = ~sw_bcd;
            clear = ($urandom_range(0, 49) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_hex_up();
        test_wrap_hex();
        test_bcd();
        test_pause();
        test_bcd_change();
        test_clear_step();
        test_blank();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
